// File: rtl/sram_march_bist_if.sv
// Single-port SRAM access bundle (enables, address, data in/out).
// master drives the request side and receives read data; slave is the inverse.
interface sram_march_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              men;
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output men, wen, ren, addr, din, input dout);
  modport slave  (input men, wen, ren, addr, din, output dout);
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST controller that owns the SRAM port: the functional port passes
// through while idle/done, and the test engine drives the macro while busy.
module sram_march_bist #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data,
  output logic [7:0]          fail_count,
  output logic [1:0]          dbg_state,
  sram_march_bist_if.slave    fn,
  sram_march_bist_if.master   mem
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              chk_q, chk_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [7:0]        fail_count_q, fail_count_d;

  logic              elem_rw, elem_down, next_down, last_addr;
  logic              eng_ren, eng_wen;
  logic [DATA_W-1:0] rd_val, wr_val;

  // Element decode: e1..e4 are read-then-write, e3/e4 walk downwards.
  always_comb begin
    elem_rw   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
    last_addr = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    rd_val    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
    wr_val    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0;
    eng_ren   = (state_q == S_RUN) && ((elem_rw && !ph_q) || (elem_q == 3'd5));
    eng_wen   = (state_q == S_RUN) && !eng_ren;
  end

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    ph_d         = ph_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    chk_d        = 1'b0;
    exp_d        = exp_q;
    chk_addr_d   = chk_addr_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_count_d = fail_count_q;

    // Read data lands one cycle after the read edge; compare it here.
    if (chk_q && (mem.dout != exp_q)) begin
      if (fail_count_q == 8'd0) begin
        fail_addr_d = chk_addr_q;
        fail_data_d = mem.dout;
      end
      if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          elem_d       = 3'd0;
          addr_d       = '0;
          ph_d         = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          fail_count_d = 8'd0;
        end
      end
      S_RUN: begin
        if (eng_ren) begin
          chk_d      = 1'b1;
          exp_d      = rd_val;
          chk_addr_d = addr_q;
        end
        if (elem_rw && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = S_FLUSH;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = next_down ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = elem_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_count_d == 8'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      elem_q       <= 3'd0;
      addr_q       <= '0;
      ph_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      chk_q        <= 1'b0;
      exp_q        <= '0;
      chk_addr_q   <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      ph_q         <= ph_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      chk_q        <= chk_d;
      exp_q        <= exp_d;
      chk_addr_q   <= chk_addr_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_count_q <= fail_count_d;
    end
  end

  // Engine side uses only registered state, so start never reaches mem_* combinationally.
  always_comb begin
    if ((state_q == S_RUN) || (state_q == S_FLUSH)) begin
      mem.men  = (state_q == S_RUN);
      mem.wen  = eng_wen;
      mem.ren  = eng_ren;
      mem.addr = addr_q;
      mem.din  = wr_val;
    end else begin
      mem.men  = fn.men;
      mem.wen  = fn.wen;
      mem.ren  = fn.ren;
      mem.addr = fn.addr;
      mem.din  = fn.din;
    end
  end

  assign fn.dout    = mem.dout;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_count = fail_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM macro model with injectable faults, a march
// reference model producing the expected port sequence and result registers.
module tb_sram_march_bist;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int N   = 1 << AW;
  localparam int OPW = 3 + AW + DW;
  // op codes: 0 none, 1 w00, 2 wFF, 3 r00, 4 rFF
  localparam int EL_OP0 [6] = '{1, 3, 4, 3, 4, 3};
  localparam int EL_OP1 [6] = '{0, 2, 1, 2, 1, 0};
  localparam bit EL_DOWN[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [7:0]    fail_count;
  logic [1:0]    dbg_state;

  sram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW)) fn_if ();
  sram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_count(fail_count),
    .dbg_state (dbg_state),
    .fn        (fn_if),
    .mem       (mem_if)
  );

  // clock
  always #5 clk = ~clk;

  // fault config: 0 none, 1 single bit stuck, 2 every word reads 0x00
  int          flt_kind = 0;
  int          flt_bit  = 0;
  logic [AW-1:0] flt_addr = '0;
  logic        flt_val  = 1'b0;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (flt_kind == 1 && a == flt_addr) r[flt_bit] = flt_val;
    else if (flt_kind == 2) r = '0;
    return r;
  endfunction

  // SRAM macro model: read data valid the cycle after the read edge
  logic [DW-1:0] sram [N];
  initial mem_if.dout = '0;
  always @(posedge clk) begin
    if (mem_if.men && mem_if.wen) sram[mem_if.addr] <= mem_if.din;
    if (mem_if.men && mem_if.ren) mem_if.dout <= faulty(mem_if.addr, sram[mem_if.addr]);
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [OPW-1:0] exp_q[$];
  logic [DW-1:0]  model_mem [N];
  int            m_fc;
  logic [AW-1:0] m_fa;
  logic [DW-1:0] m_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // March C- walked element by element; yields port ops and the result registers.
  task automatic build_model();
    exp_q.delete();
    m_fc = 0;
    m_fa = '0;
    m_fd = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = EL_DOWN[e] ? (N - 1 - i) : i;
        for (int k = 0; k < 2; k++) begin
          int op;
          logic [DW-1:0] v;
          logic [DW-1:0] got;
          op = (k == 0) ? EL_OP0[e] : EL_OP1[e];
          v  = (op == 2 || op == 4) ? 8'hFF : 8'h00;
          if (op == 1 || op == 2) begin
            model_mem[a] = v;
            exp_q.push_back({3'b110, AW'(a), v});
          end else if (op >= 3) begin
            exp_q.push_back({3'b101, AW'(a), 8'h00});
            got = faulty(AW'(a), model_mem[a]);
            if (got != v) begin
              if (m_fc == 0) begin
                m_fa = AW'(a);
                m_fd = got;
              end
              if (m_fc < 255) m_fc++;
            end
          end
        end
      end
    end
  endtask

  task automatic reset_checks();
    logic [OPW-1:0] f;
    logic [OPW-1:0] m;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    fn_if.men = 1'b1; fn_if.wen = 1'($urandom_range(0, 1)); fn_if.ren = ~fn_if.wen;
    fn_if.addr = AW'($urandom_range(0, N - 1)); fn_if.din = DW'($urandom_range(0, 255));
    #1;
    f = {fn_if.men, fn_if.wen, fn_if.ren, fn_if.addr, fn_if.din};
    m = {mem_if.men, mem_if.wen, mem_if.ren, mem_if.addr, mem_if.din};
    check("rst_port_mux", m, f);
    fn_if.men = 1'b0; fn_if.wen = 1'b0; fn_if.ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare process for one run: the next posedge is the accepting edge.
  task automatic march_body(input bit hold, input int abort_at);
    logic [OPW-1:0] a;
    logic [OPW-1:0] e;
    build_model();
    @(posedge clk);
    for (int cyc = 1; cyc <= 10 * N + 1; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (cyc == 1) check("done_clear_on_accept", done, 0);
      check("busy_during_run", busy, 1);
      if (cyc == abort_at) begin
        reset_checks();
        return;
      end
      if (cyc <= 10 * N) begin
        a = {mem_if.men, mem_if.wen, mem_if.ren, mem_if.addr, mem_if.din};
        e = exp_q.pop_front();
        if (!e[OPW-2]) a[DW-1:0] = '0;
        check("port_op", a, e);
        check("wen_and_ren", mem_if.wen & mem_if.ren, 0);
        if (cyc == 1)         check("e0_first_op", a, {3'b110, 10'h000, 8'h00});
        if (cyc == N)         check("e0_last_op",  a, {3'b110, 10'h3FF, 8'h00});
        if (cyc == 5 * N + 1) check("e3_first_rd", a, {3'b101, 10'h3FF, 8'h00});
        if (cyc == 5 * N + 2) check("e3_first_wr", a, {3'b110, 10'h3FF, 8'hFF});
      end else begin
        check("done_low_in_flush", done, 0);
      end
    end
    @(negedge clk);
    check("done_set", done, 1);
    check("busy_fall", busy, 0);
    check("pass", pass, (m_fc == 0) ? 1 : 0);
    check("fail_count", fail_count, m_fc);
    check("fail_addr", fail_addr, m_fa);
    check("fail_data", fail_data, m_fd);
  endtask

  task automatic fn_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    fn_if.men = 1'b1; fn_if.wen = 1'b1; fn_if.ren = 1'b0; fn_if.addr = ad; fn_if.din = d;
    #1;
    check("idle_mux_wr", {mem_if.men, mem_if.wen, mem_if.ren, mem_if.addr, mem_if.din},
          {3'b110, ad, d});
  endtask

  task automatic fn_read_check(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    fn_if.men = 1'b1; fn_if.wen = 1'b0; fn_if.ren = 1'b1; fn_if.addr = ad;
    @(negedge clk);
    fn_if.men = 1'b0; fn_if.ren = 1'b0;
    check("fn_dout", fn_if.dout, d);
  endtask

  initial begin
    logic [AW-1:0] ra [4];
    logic [DW-1:0] rd [4];
    fn_if.men = 1'b0; fn_if.wen = 1'b0; fn_if.ren = 1'b0;
    fn_if.addr = '0; fn_if.din = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_fail_count", fail_count, 0);
    check("reset_fail_addr", fail_addr, 0);
    check("reset_fail_data", fail_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // functional port in IDLE
    fn_write(10'h2A3, 8'hA5);
    fn_read_check(10'h2A3, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      ra[i] = AW'(i * 256 + $urandom_range(0, 255));
      rd[i] = DW'($urandom_range(0, 255));
      fn_write(ra[i], rd[i]);
    end
    for (int i = 0; i < 4; i++) fn_read_check(ra[i], rd[i]);

    // clean memory, pulsed start
    @(negedge clk); start = 1'b1;
    march_body(1'b0, 0);
    check("clean_pass", pass, 1);
    check("clean_count", fail_count, 0);

    // bit 3 of 0x155 stuck at 1
    flt_kind = 1; flt_addr = 10'h155; flt_bit = 3; flt_val = 1'b1;
    @(negedge clk); start = 1'b1;
    march_body(1'b0, 0);
    check("sa1_pass", pass, 0);
    check("sa1_addr", fail_addr, 10'h155);
    check("sa1_data", fail_data, 8'h08);
    check("sa1_count", fail_count, 3);

    // every word reads 0x00
    flt_kind = 2;
    @(negedge clk); start = 1'b1;
    march_body(1'b0, 0);
    check("zero_pass", pass, 0);
    check("zero_addr", fail_addr, 10'h000);
    check("zero_data", fail_data, 8'h00);
    check("zero_count", fail_count, 255);

    // random single-bit fault, start held through the run and into DONE
    flt_kind = 1;
    flt_addr = AW'($urandom_range(0, N - 1));
    flt_bit  = $urandom_range(0, DW - 1);
    flt_val  = 1'($urandom_range(0, 1));
    @(negedge clk); start = 1'b1;
    march_body(1'b1, 0);
    march_body(1'b0, 0);

    // reset mid-run, then a full clean run
    flt_kind = 0;
    @(negedge clk); start = 1'b1;
    march_body(1'b0, 5000);
    @(negedge clk); start = 1'b1;
    march_body(1'b0, 0);
    check("post_reset_pass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
